// File: rtl/dc_cal_pkg.sv
// ============================================================================
// dc_cal_pkg : shared types and helpers for the DC-offset calibration block
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

package dc_cal_pkg;

    localparam int DAC_W    = 6;
    localparam int SIGN_BIT = 5;
    localparam int MAG_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_DECIDE = 3'd3,
        ST_FINISH = 3'd4
    } cal_state_t;

    typedef enum logic [1:0] {
        AVG_IDLE   = 2'd0,
        AVG_SETTLE = 2'd1,
        AVG_ACCUM  = 2'd2
    } avg_state_t;

    // Sign-magnitude pack; a zero magnitude never carries a negative sign.
    function automatic logic [DAC_W-1:0] sm_encode(input logic sign,
                                                   input logic [MAG_W-1:0] mag);
        return (mag == '0) ? '0 : {sign, mag};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dc_cal_avg.sv
// ============================================================================
// dc_cal_avg : settle delay, N-sample ADC accumulator and mid-code comparator
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module dc_cal_avg
    import dc_cal_pkg::*;
#(
    parameter int ADC_W         = 8,
    parameter int MID_CODE      = 128,
    parameter int LOG2_N        = 4,
    parameter int SETTLE_CYCLES = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             restart,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    output logic             settled,
    output logic             decision_valid,
    output logic             above
);

    localparam int SUM_W  = ADC_W + LOG2_N;
    localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYCLES - 1);
    localparam logic [LOG2_N-1:0] LAST_SAMPLE = '1;
    localparam logic [SUM_W-1:0]  THRESH      = SUM_W'(MID_CODE) << LOG2_N;

    avg_state_t        state;
    avg_state_t        state_nx;
    logic [SCNT_W-1:0] settle_cnt;
    logic [LOG2_N-1:0] sample_cnt;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_next;
    logic              above_q;

    assign sum_next       = sum + SUM_W'(adc_data);
    assign settled        = (state == AVG_SETTLE) && (settle_cnt == SETTLE_LAST);
    assign decision_valid = (state == AVG_ACCUM) && adc_valid && (sample_cnt == LAST_SAMPLE);
    assign above          = above_q;

    always_comb begin
        state_nx = state;
        case (state)
            AVG_SETTLE: if (settle_cnt == SETTLE_LAST) state_nx = AVG_ACCUM;
            AVG_ACCUM:  if (decision_valid)            state_nx = AVG_IDLE;
            default:    state_nx = state;
        endcase
        if (restart) state_nx = AVG_SETTLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= AVG_IDLE;
            settle_cnt <= '0;
            sample_cnt <= '0;
            sum        <= '0;
            above_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (restart) begin
                settle_cnt <= '0;
                sample_cnt <= '0;
                sum        <= '0;
            end else begin
                if (state == AVG_SETTLE) settle_cnt <= settle_cnt + SCNT_W'(1);
                if ((state == AVG_ACCUM) && adc_valid) begin
                    sum        <= sum_next;
                    sample_cnt <= sample_cnt + LOG2_N'(1);
                end
                // Strict compare: an exact tie with the target reads as "not above".
                if (decision_valid) above_q <= (sum_next > THRESH);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dc_offset_cal.sv
// ============================================================================
// dc_offset_cal : SAR DC-offset calibration controller for a 6-bit SM DAC
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module dc_offset_cal
    import dc_cal_pkg::*;
#(
    parameter int ADC_W         = 8,
    parameter int MID_CODE      = 128,
    parameter int LOG2_N        = 4,
    parameter int SETTLE_CYCLES = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             override_en,
    input  logic [5:0]       override_code,
    output logic [5:0]       current_dac,
    output logic             busy,
    output logic             done,
    output logic [5:0]       cal_code
);

    localparam int IDX_W = $clog2(MAG_W);
    localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(MAG_W - 1);
    localparam logic [MAG_W-1:0] FIRST_MAG = MAG_W'(1) << (MAG_W - 1);

    cal_state_t       state;
    cal_state_t       state_nx;
    logic [DAC_W-1:0] trial_code;
    logic [DAC_W-1:0] trial_next;
    logic [DAC_W-1:0] cal_code_q;
    logic [IDX_W-1:0] bit_idx;
    logic             sign_phase;
    logic             done_q;
    logic             restart;
    logic             settled;
    logic             decision_valid;
    logic             above;
    logic             last_bit;
    logic             keep;
    logic [MAG_W-1:0] trial_mag;
    logic [MAG_W-1:0] mag_kept;
    logic [MAG_W-1:0] bit_mask;
    logic [MAG_W-1:0] next_mask;

    dc_cal_avg #(
        .ADC_W         (ADC_W),
        .MID_CODE      (MID_CODE),
        .LOG2_N        (LOG2_N),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_avg (
        .clock          (clock),
        .reset_n        (reset_n),
        .restart        (restart),
        .adc_valid      (adc_valid),
        .adc_data       (adc_data),
        .settled        (settled),
        .decision_valid (decision_valid),
        .above          (above)
    );

    // SAR step: with a negative trim the residual has not crossed while still above,
    // with a positive trim while still not above.
    assign trial_mag = trial_code[MAG_W-1:0];
    assign last_bit  = !sign_phase && (bit_idx == '0);
    assign keep      = trial_code[SIGN_BIT] ? above : !above;
    assign bit_mask  = MAG_W'(1) << bit_idx;
    assign next_mask = MAG_W'(1) << (bit_idx - IDX_W'(1));
    assign mag_kept  = keep ? trial_mag : (trial_mag & ~bit_mask);

    always_comb begin
        trial_next = trial_code;
        if (sign_phase)
            trial_next = {above, FIRST_MAG};
        else if (last_bit)
            trial_next = sm_encode(trial_code[SIGN_BIT], mag_kept);
        else
            trial_next = {trial_code[SIGN_BIT], mag_kept | next_mask};
    end

    always_comb begin
        state_nx = state;
        restart  = 1'b0;
        if (override_en) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nx = ST_SETTLE;
                        restart  = 1'b1;
                    end
                end
                ST_SETTLE: if (settled)        state_nx = ST_ACCUM;
                ST_ACCUM:  if (decision_valid) state_nx = ST_DECIDE;
                ST_DECIDE: begin
                    if (last_bit) begin
                        state_nx = ST_FINISH;
                    end else begin
                        state_nx = ST_SETTLE;
                        restart  = 1'b1;
                    end
                end
                ST_FINISH: state_nx = ST_IDLE;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            trial_code <= '0;
            cal_code_q <= '0;
            bit_idx    <= '0;
            sign_phase <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!override_en) begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            trial_code <= '0;
                            sign_phase <= 1'b1;
                            bit_idx    <= TOP_IDX;
                        end
                    end
                    ST_DECIDE: begin
                        trial_code <= trial_next;
                        if (sign_phase) begin
                            sign_phase <= 1'b0;
                            bit_idx    <= TOP_IDX;
                        end else if (!last_bit) begin
                            bit_idx <= bit_idx - IDX_W'(1);
                        end
                    end
                    ST_FINISH: begin
                        cal_code_q <= trial_code;
                        done_q     <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy        = (state != ST_IDLE);
    assign done        = done_q;
    assign cal_code    = cal_code_q;
    assign current_dac = override_en ? override_code : (busy ? trial_code : cal_code_q);

endmodule

`default_nettype wire

// File: tb/tb_dc_offset_cal.sv
// ============================================================================
// tb_dc_offset_cal : closed-loop bench (controller -> DAC/offset model -> ADC)
// Revision         : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dc_offset_cal;

    // Voltages are held in 50 uV units: DAC LSB 0.195 V = 3900, ADC LSB 0.04875 V = 975.
    localparam int DAC_LSB = 3900;
    localparam int ADC_LSB = 975;
    localparam int SETTLE  = 32;
    localparam int NSAMP   = 16;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start = 1'b0;
    logic       adc_valid = 1'b1;
    logic [7:0] adc_data;
    logic       override_en = 1'b0;
    logic [5:0] override_code = 6'd0;
    logic [5:0] current_dac;
    logic       busy;
    logic       done;
    logic [5:0] cal_code;

    int  offset = 0;
    bit  slow_valid = 1'b0;
    int  vc = 0;
    int  n_checks = 0;
    int  n_pass = 0;

    logic [5:0] m_trial = 6'd0;
    logic [5:0] m_cal = 6'd0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;

    dc_offset_cal dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .override_en   (override_en),
        .override_code (override_code),
        .current_dac   (current_dac),
        .busy          (busy),
        .done          (done),
        .cal_code      (cal_code)
    );

    always #5 clock = ~clock;

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int plant(input logic [5:0] code, input int off);
        int v;
        int a;
        v = off + (code[5] ? -1 : 1) * int'(code[4:0]) * DAC_LSB;
        a = 128 + fdiv(v, ADC_LSB);
        if (a < 0) a = 0;
        if (a > 255) a = 255;
        return a;
    endfunction

    always_comb adc_data = 8'(plant(current_dac, offset));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    initial forever begin
        @(posedge clock);
        #2;
        vc = (vc == 2) ? 0 : vc + 1;
        adc_valid = !slow_valid || (vc == 0);
    end

    // ---------------- behavioural model ----------------
    task automatic tick(output bit ab);
        @(posedge clock);
        ab = !reset_n || override_en;
        if (!reset_n) m_cal = 6'd0;
        if (ab) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end
    endtask

    task automatic run_cal();
        bit         ab;
        bit         sgn;
        bit         above;
        logic [4:0] mag;
        int         got;
        int         k;
        m_busy  = 1'b1;
        m_trial = 6'd0;
        sgn     = 1'b0;
        mag     = 5'd0;
        for (int d = 0; d < 6; d++) begin
            for (int s = 0; s < SETTLE; s++) begin
                tick(ab);
                if (ab) return;
            end
            got = 0;
            while (got < NSAMP) begin
                tick(ab);
                if (ab) return;
                if (adc_valid) got++;
            end
            tick(ab);
            if (ab) return;
            above = (NSAMP * plant(m_trial, offset)) > (128 * NSAMP);
            if (d == 0) begin
                sgn = above;
                mag = 5'b10000;
            end else begin
                k = 5 - d;
                if (!(sgn ? above : !above)) mag[k] = 1'b0;
                if (k > 0) mag[k-1] = 1'b1;
            end
            m_trial = (d == 5 && mag == 5'd0) ? 6'd0 : {sgn, mag};
        end
        tick(ab);
        if (ab) return;
        m_busy = 1'b0;
        m_done = 1'b1;
        m_cal  = m_trial;
    endtask

    initial forever begin
        @(posedge clock);
        if (!reset_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cal  = 6'd0;
        end else begin
            m_done = 1'b0;
            if (start && !override_en) run_cal();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        logic [5:0] e_dac;
        e_dac = override_en ? override_code :
                (!reset_n ? 6'd0 : (m_busy ? m_trial : m_cal));
        check("cyc_busy", int'(busy), !reset_n ? 0 : int'(m_busy));
        check("cyc_done", int'(done), !reset_n ? 0 : int'(m_done));
        check("cyc_dac",  int'(current_dac), int'(e_dac));
        check("cyc_cal",  int'(cal_code), !reset_n ? 0 : int'(m_cal));
    end

    task automatic run_case(input int off, input bit slow, input bit poke, output int lat);
        offset     = off;
        slow_valid = slow;
        cyc(2);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 2000; i++) begin
            if (poke && i == 100) start = 1'b1;
            if (poke && i == 101) start = 1'b0;
            cyc(1);
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 0, 1);
        cyc(1);
    endtask

    initial begin
        int lat;
        int ndone;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        cyc(1);

        check("plant_neg05_zero", plant(6'b000000, -10000), 117);
        check("plant_neg05_code2", plant(6'b000010, -10000), 125);
        check("plant_pos1_code37", plant(6'b100101, 20000), 128);

        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cal",  int'(cal_code), 0);
        check("rst_dac",  int'(current_dac), 0);

        run_case(20000, 1'b0, 1'b0, lat);
        check("pos1_latency", lat, 295);
        check("pos1_cal_vs_model", int'(cal_code), int'(m_cal));
        check("pos1_dac_holds_cal", int'(current_dac), int'(m_cal));

        run_case(-10000, 1'b0, 1'b1, lat);
        check("neg05_latency_with_poke", lat, 295);
        check("neg05_cal", int'(cal_code), 6'b000010);

        run_case(0, 1'b0, 1'b0, lat);
        check("zero_cal", int'(cal_code), 6'b000000);

        run_case(140000, 1'b0, 1'b0, lat);
        check("pos7_cal", int'(cal_code), 6'b111111);

        run_case(-140000, 1'b0, 1'b0, lat);
        check("neg7_cal", int'(cal_code), 6'b011111);

        run_case(-10000, 1'b1, 1'b0, lat);
        check("slow_neg05_cal", int'(cal_code), 6'b000010);
        check("slow_neg05_stretched", int'(lat > 295), 1);

        run_case(140000, 1'b1, 1'b1, lat);
        check("slow_pos7_cal", int'(cal_code), 6'b111111);

        run_case(-140000, 1'b1, 1'b0, lat);
        check("slow_neg7_cal", int'(cal_code), 6'b011111);
        slow_valid = 1'b0;

        // Manual override while idle: passes straight through and blocks start.
        override_en   = 1'b1;
        override_code = 6'b100111;
        #1 check("ovr_dac", int'(current_dac), 6'b100111);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
        check("ovr_start_ignored", int'(busy), 0);
        override_en = 1'b0;
        cyc(1);

        // Override raised mid-calibration aborts without a result.
        offset = 20000;
        start  = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(100);
        override_en = 1'b1;
        cyc(1);
        check("ovr_abort_busy", int'(busy), 0);
        override_en = 1'b0;
        ndone = 0;
        for (int i = 0; i < 350; i++) begin
            cyc(1);
            if (done) ndone++;
        end
        check("ovr_abort_no_done", ndone, 0);
        check("ovr_abort_cal_kept", int'(cal_code), 6'b011111);

        // Reset during accumulation of magnitude bit 2.
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(185);
        reset_n = 1'b0;
        #1;
        check("arst_dac",  int'(current_dac), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_cal",  int'(cal_code), 0);
        cyc(2);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(1);
            if (done) ndone++;
        end
        check("arst_no_done", ndone, 0);
        check("arst_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
